// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared types and default sizing for the truth-table sweeper
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Default build sizing; the top recomputes these from its own parameters.
  localparam int N_IN_DEF   = 4;
  localparam int SETTLE_DEF = 1;
  localparam int N_VEC      = 1 << N_IN_DEF;
  localparam int CNT_W      = $clog2(SETTLE_DEF + 1);

endpackage

// File: rtl/tt_settle_counter.sv
// rtl/tt_settle_counter.sv - loadable down-counter with zero flag for the settle delay
module tt_settle_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero so the flag stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all input vectors into two implementations and compares them (option: SWEEP_EARLY_STOP_EN)
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        vec_out,
  input  logic                   f_a,
  input  logic                   f_b,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   minterms_a,
  output logic [(1<<N_IN)-1:0]   minterms_b,
  output logic [N_IN:0]          mismatch_cnt,
  output logic [N_IN-1:0]        first_mismatch,
  output logic                   equiv
);

  localparam int CW = $clog2(SETTLE + 1);

  state_t state;
  state_t state_next;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_zero;

  tt_settle_counter #(.W(CW)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CW'(SETTLE - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and settle-counter control.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DRIVE;
          cnt_load   = 1'b1;
        end
      end
      DRIVE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (vec_out == '1) begin
          state_next = FINISH;
        end else begin
          state_next = DRIVE;
        end
`ifdef SWEEP_EARLY_STOP_EN
        if (f_a != f_b) begin
          state_next = FINISH;
        end
`endif
        cnt_load = (state_next == DRIVE);
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Vector stepping, response capture and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      minterms_a     <= '0;
      minterms_b     <= '0;
      mismatch_cnt   <= '0;
      first_mismatch <= '0;
      equiv          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_out        <= '0;
            busy           <= 1'b1;
            minterms_a     <= '0;
            minterms_b     <= '0;
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            equiv          <= 1'b0;
          end
        end
        SAMPLE: begin
          minterms_a[vec_out] <= f_a;
          minterms_b[vec_out] <= f_b;
          if (f_a != f_b) begin
            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
            if (mismatch_cnt == '0) begin
              first_mismatch <= vec_out;
            end
          end
          if (state_next == DRIVE) begin
            vec_out <= vec_out + N_IN'(1);
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          equiv <= (mismatch_cnt == '0);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sel4 = 1'b0;
  logic [15:0] tt_a = '0;
  logic [15:0] tt_b = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instance with N_IN=4, SETTLE=2
  logic [3:0]  vec4, first4;
  logic        busy4, done4, eq4;
  logic [15:0] ma4, mb4;
  logic [4:0]  cnt4;
  logic        fa4, fb4, start4;

  // Instance with N_IN=2, SETTLE=1
  logic [1:0]  vec2, first2;
  logic        busy2, done2, eq2;
  logic [3:0]  ma2, mb2;
  logic [2:0]  cnt2;
  logic        fa2, fb2, start2;
  logic [3:0]  tt_a2, tt_b2;

  assign start4 = start & sel4;
  assign start2 = start & ~sel4;
  assign fa4 = tt_a[vec4];
  assign fb4 = tt_b[vec4];
  assign tt_a2 = tt_a[3:0];
  assign tt_b2 = tt_b[3:0];
  assign fa2 = tt_a2[vec2];
  assign fb2 = tt_b2[vec2];

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .vec_out(vec4), .f_a(fa4), .f_b(fb4),
    .busy(busy4), .done(done4), .minterms_a(ma4), .minterms_b(mb4),
    .mismatch_cnt(cnt4), .first_mismatch(first4), .equiv(eq4)
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec2), .f_a(fa2), .f_b(fb2),
    .busy(busy2), .done(done2), .minterms_a(ma2), .minterms_b(mb2),
    .mismatch_cnt(cnt2), .first_mismatch(first2), .equiv(eq2)
  );

  logic [3:0]  o_vec, o_first;
  logic        o_busy, o_done, o_eq;
  logic [15:0] o_ma, o_mb;
  logic [4:0]  o_cnt;

  always_comb begin
    if (sel4) begin
      o_vec = vec4; o_first = first4; o_busy = busy4; o_done = done4; o_eq = eq4;
      o_ma = ma4; o_mb = mb4; o_cnt = cnt4;
    end else begin
      o_vec = {2'b00, vec2}; o_first = {2'b00, first2}; o_busy = busy2; o_done = done2;
      o_eq = eq2; o_ma = {12'h000, ma2}; o_mb = {12'h000, mb2}; o_cnt = {2'b00, cnt2};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec"},   32'(o_vec), 0);
    check({tag, "_busy"},  32'(o_busy), 0);
    check({tag, "_done"},  32'(o_done), 0);
    check({tag, "_ma"},    32'(o_ma), 0);
    check({tag, "_mb"},    32'(o_mb), 0);
    check({tag, "_cnt"},   32'(o_cnt), 0);
    check({tag, "_first"}, 32'(o_first), 0);
    check({tag, "_equiv"}, 32'(o_eq), 0);
  endtask

  // Reference: expected results derived from the two truth tables directly.
  task automatic run_sweep(input string tag, input bit hold_start);
    int n, s, lat, c, k, ecnt, extra;
    logic [15:0] mask, diff, ema, emb, km;
    n = sel4 ? 16 : 4;
    s = sel4 ? 2 : 1;
    mask = sel4 ? 16'hFFFF : 16'h000F;
    diff = (tt_a ^ tt_b) & mask;
    ecnt = 0;
    k = -1;
    for (int i = 0; i < n; i++) begin
      if (diff[i]) begin
        ecnt++;
        if (k < 0) k = i;
      end
    end
    ema = tt_a & mask;
    emb = tt_b & mask;
    lat = n * (s + 1) + 1;
`ifdef SWEEP_EARLY_STOP_EN
    if (k >= 0) begin
      km = 16'((32'd2 << k) - 32'd1);
      ema = ema & km;
      emb = emb & km;
      ecnt = 1;
      lat = (k + 1) * (s + 1) + 1;
    end
`endif
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_busy_on"}, 32'(o_busy), 1);
    if (!hold_start) start = 1'b0;
    c = 0;
    while (c < 400) begin
      @(posedge clk);
      #1;
      c++;
      if (o_done) break;
    end
    start = 1'b0;
    check({tag, "_latency"}, c, lat);
    check({tag, "_ma"},    32'(o_ma), 32'(ema));
    check({tag, "_mb"},    32'(o_mb), 32'(emb));
    check({tag, "_cnt"},   32'(o_cnt), ecnt);
    check({tag, "_first"}, 32'(o_first), (k >= 0) ? k : 0);
    check({tag, "_equiv"}, 32'(o_eq), (ecnt == 0) ? 1 : 0);
    check({tag, "_busy_off"}, 32'(o_busy), 0);
    extra = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (o_done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_ma_hold"}, 32'(o_ma), 32'(ema));
  endtask

  initial begin
    int c, a, b, cc, d;
    #12;
    sel4 = 1'b0;
    #1 check_zero("rst2");
    sel4 = 1'b1;
    #1 check_zero("rst4");
    @(negedge clk);
    rst_n = 1'b1;

    // Two-input AND vs AND, then AND vs OR
    sel4 = 1'b0;
    tt_a = '0;
    tt_b = '0;
    for (int v = 0; v < 4; v++) begin
      a = (v >> 1) & 1; b = v & 1;
      tt_a[v] = 1'(a & b);
      tt_b[v] = 1'(a & b);
    end
    run_sweep("and_and", 1'b0);
    for (int v = 0; v < 4; v++) begin
      a = (v >> 1) & 1; b = v & 1;
      tt_b[v] = 1'(a | b);
    end
    run_sweep("and_or", 1'b0);
    run_sweep("and_or_repulse", 1'b1);

    // Four-input expressions
    sel4 = 1'b1;
    for (int v = 0; v < 16; v++) begin
      a = (v >> 3) & 1; b = (v >> 2) & 1; cc = (v >> 1) & 1; d = v & 1;
      tt_a[v] = 1'(((1 - a) & d) | (a & (1 - b)));
      tt_b[v] = 1'(((1 - a) & (1 - cc) & d) | (a & (1 - b)) | ((1 - b) & d));
    end
    run_sweep("expr4", 1'b0);

    // Randomized tables: equal, single-bit flip, independent
    for (int r = 0; r < 9; r++) begin
      sel4 = 1'(r % 2);
      tt_a = 16'($urandom);
      case (r % 3)
        0: tt_b = tt_a;
        1: tt_b = tt_a ^ (16'd1 << (sel4 ? $urandom_range(15, 0) : $urandom_range(3, 0)));
        default: tt_b = 16'($urandom);
      endcase
      run_sweep($sformatf("rand%0d", r), 1'(r == 5));
    end

    // Reset mid-sweep at vector 3, then a clean sweep
    sel4 = 1'b1;
    tt_a = 16'($urandom);
    tt_b = 16'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    c = 0;
    while (o_vec != 4'd3 && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    check("mid_vec3", 32'(o_vec), 3);
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    c = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (o_done || o_busy) c++;
    end
    check("midrst_quiet", c, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
